// File: rtl/store_buffer.sv
// Store buffer between a core and a single-port data RAM.
// Holds up to DEPTH pending stores in a circular FIFO. Loads get the RAM port
// first and see forwarded data from the youngest matching entry. When no load
// is present, the oldest entry drains to the RAM.
module store_buffer #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic        re,
  input  logic [31:0] a,
  input  logic [31:0] wd,
  output logic [31:0] rd,
  output logic        stall,
  output logic        empty,
  output logic        mem_we,
  output logic [31:0] mem_a,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

  logic [29:0]    addr_r [DEPTH];
  logic [31:0]    data_r [DEPTH];
  logic [DEPTH-1:0] valid_r;
  logic [PW-1:0]  head_r;
  logic [PW-1:0]  tail_r;
  logic [PW:0]    count_r;

  logic           accept_s;
  logic           drain_s;
  logic           fwd_hit_s;
  logic [31:0]    fwd_data_s;
  logic [PW-1:0]  idx_s;

  // Acceptance and drain decisions; stall looks at count before any same-cycle drain.
  always_comb begin
    stall    = we & (count_r == FULL);
    accept_s = we & ~stall;
    drain_s  = ~re & (count_r != {(PW+1){1'b0}});
    empty    = (count_r == {(PW+1){1'b0}});
  end

  // Walk entries oldest to youngest so the last match wins (youngest store).
  always_comb begin
    fwd_hit_s  = 1'b0;
    fwd_data_s = 32'h0000_0000;
    idx_s      = head_r;
    for (int k = 0; k < DEPTH; k++) begin
      idx_s = head_r + PW'(k);
      if (valid_r[idx_s] && (addr_r[idx_s] == a[31:2])) begin
        fwd_hit_s  = 1'b1;
        fwd_data_s = data_r[idx_s];
      end else begin
        fwd_hit_s  = fwd_hit_s;
        fwd_data_s = fwd_data_s;
      end
    end
  end

  // Load data: forwarded entry when a load hits, otherwise the RAM read data.
  always_comb begin
    rd = mem_rd;
    if (re && fwd_hit_s) begin
      rd = fwd_data_s;
    end else begin
      rd = mem_rd;
    end
  end

  // RAM port arbitration: a load owns the port, otherwise the head entry drains.
  always_comb begin
    mem_we = 1'b0;
    mem_a  = {a[31:2], 2'b00};
    mem_wd = data_r[head_r];
    if (drain_s) begin
      mem_we = 1'b1;
      mem_a  = {addr_r[head_r], 2'b00};
    end else begin
      mem_we = 1'b0;
      mem_a  = {a[31:2], 2'b00};
    end
  end

  // Entry payload storage; not cleared by reset since valid bits gate its use.
  always_ff @(posedge clk) begin
    if (accept_s) begin
      addr_r[tail_r] <= a[31:2];
      data_r[tail_r] <= wd;
    end
  end

  // Pointers, occupancy and valid bits.
  always_ff @(posedge clk) begin
    if (reset) begin
      head_r  <= '0;
      tail_r  <= '0;
      count_r <= '0;
      valid_r <= '0;
    end else begin
      if (accept_s) begin
        valid_r[tail_r] <= 1'b1;
        tail_r          <= tail_r + 1'b1;
      end
      if (drain_s) begin
        valid_r[head_r] <= 1'b0;
        head_r          <= head_r + 1'b1;
      end
      case ({accept_s, drain_s})
        2'b10:   count_r <= count_r + 1'b1;
        2'b01:   count_r <= count_r - 1'b1;
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Bench for store_buffer: directed scenarios followed by random traffic, all
// checked against a queue-based model of pending stores and a model RAM.
module tb_store_buffer;

  localparam int DEPTH = 4;

  logic        clk;
  logic        reset;
  logic        we;
  logic        re;
  logic [31:0] a;
  logic [31:0] wd;
  logic [31:0] rd;
  logic        stall;
  logic        empty;
  logic        mem_we;
  logic [31:0] mem_a;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd;

  typedef struct {
    logic [29:0] addr;
    logic [31:0] data;
  } entry_t;

  entry_t      q[$];
  logic [31:0] mram [64];
  logic [31:0] tram [64];

  int n_vec;
  int n_err;

  logic [31:0] obs_rd;
  logic        obs_stall;
  logic        obs_empty;
  logic        obs_mem_we;
  logic [31:0] obs_mem_a;
  logic [31:0] obs_mem_wd;

  store_buffer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .we(we), .re(re), .a(a), .wd(wd),
    .rd(rd), .stall(stall), .empty(empty),
    .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  assign mem_rd = tram[mem_a[7:2]];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic poke(input logic [31:0] addr, input logic [31:0] val);
    mram[addr[7:2]] = val;
    tram[addr[7:2]] = val;
  endtask

  // One clock cycle: drive, check outputs against the model, clock, update model.
  task automatic step(input logic w, input logic r, input logic [31:0] addr,
                      input logic [31:0] data, input logic rs);
    logic        e_stall, e_drain, e_accept, e_mem_we;
    logic [31:0] e_mem_a, e_mem_wd, e_rd;
    logic        hit;
    @(negedge clk);
    we = w; re = r; a = addr; wd = data; reset = rs;
    #1;
    e_stall  = w && (q.size() == DEPTH);
    e_accept = w && !e_stall;
    e_drain  = !r && (q.size() > 0);
    e_mem_we = e_drain;
    e_mem_a  = e_drain ? {q[0].addr, 2'b00} : {addr[31:2], 2'b00};
    e_mem_wd = e_drain ? q[0].data : 32'h0;
    if (r) begin
      hit = 1'b0;
      e_rd = mram[addr[7:2]];
      for (int i = q.size() - 1; i >= 0; i--) begin
        if (!hit && q[i].addr == addr[31:2]) begin
          hit = 1'b1;
          e_rd = q[i].data;
        end
      end
    end else begin
      e_rd = mram[e_mem_a[7:2]];
    end
    obs_rd = rd; obs_stall = stall; obs_empty = empty;
    obs_mem_we = mem_we; obs_mem_a = mem_a; obs_mem_wd = mem_wd;
    check("stall", {31'h0, stall}, {31'h0, e_stall});
    check("empty", {31'h0, empty}, {31'h0, (q.size() == 0)});
    check("mem_we", {31'h0, mem_we}, {31'h0, e_mem_we});
    check("mem_a", mem_a, e_mem_a);
    check("rd", rd, e_rd);
    if (e_mem_we) check("mem_wd", mem_wd, e_mem_wd);
    @(posedge clk);
    if (obs_mem_we) tram[obs_mem_a[7:2]] = obs_mem_wd;
    if (e_drain) mram[e_mem_a[7:2]] = e_mem_wd;
    if (rs) begin
      q.delete();
    end else begin
      if (e_drain) void'(q.pop_front());
      if (e_accept) q.push_back('{addr: addr[31:2], data: data});
    end
  endtask

  task automatic drain_all();
    for (int i = 0; i < 2 * DEPTH && q.size() > 0; i++) step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    check("drain_done", {31'h0, obs_empty | (q.size() == 0)}, 32'h1);
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    we = 1'b0; re = 1'b0; a = 32'h0; wd = 32'h0; reset = 1'b1;
    for (int i = 0; i < 64; i++) begin
      mram[i] = 32'h0;
      tram[i] = 32'h0;
    end
    repeat (2) @(posedge clk);
    step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);

    // Reset state
    step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    check("rst_empty", {31'h0, obs_empty}, 32'h1);
    check("rst_mem_we", {31'h0, obs_mem_we}, 32'h0);
    check("rst_stall", {31'h0, obs_stall}, 32'h0);

    // Single store then drain
    step(1'b1, 1'b0, 32'h50, 32'd72, 1'b0);
    check("s1_stall", {31'h0, obs_stall}, 32'h0);
    step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    check("s1_mem_we", {31'h0, obs_mem_we}, 32'h1);
    check("s1_mem_a", obs_mem_a, 32'h50);
    check("s1_mem_wd", obs_mem_wd, 32'd72);
    step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    check("s1_empty", {31'h0, obs_empty}, 32'h1);

    // Fill while loads hold the port, then full-stall and retry
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 32'h40 + 32'(4 * i), 32'(i + 1), 1'b0);
    step(1'b1, 1'b1, 32'h54, 32'd5, 1'b0);
    check("full_stall", {31'h0, obs_stall}, 32'h1);
    step(1'b1, 1'b0, 32'h54, 32'd5, 1'b0);
    check("full_drain_stall", {31'h0, obs_stall}, 32'h1);
    check("full_drain_a", obs_mem_a, 32'h40);
    check("full_drain_wd", obs_mem_wd, 32'd1);
    step(1'b1, 1'b0, 32'h54, 32'd5, 1'b0);
    check("retry_accept", {31'h0, obs_stall}, 32'h0);
    drain_all();

    // Same-address stores: youngest forwarded, drained in order
    step(1'b1, 1'b1, 32'h54, 32'd7, 1'b0);
    step(1'b1, 1'b1, 32'h54, 32'd9, 1'b0);
    step(1'b0, 1'b1, 32'h54, 32'h0, 1'b0);
    check("fwd_youngest", obs_rd, 32'd9);
    step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    check("order_first", obs_mem_wd, 32'd7);
    step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    check("order_second", obs_mem_wd, 32'd9);
    check("order_addr", obs_mem_a, 32'h54);

    // Load miss goes to RAM
    poke(32'h60, 32'h1234);
    step(1'b0, 1'b1, 32'h60, 32'h0, 1'b0);
    check("miss_rd", obs_rd, 32'h1234);
    check("miss_mem_we", {31'h0, obs_mem_we}, 32'h0);

    // Same-cycle load sees pre-store value
    poke(32'h44, 32'd3);
    step(1'b1, 1'b1, 32'h44, 32'd5, 1'b0);
    check("same_cycle_rd", obs_rd, 32'd3);
    step(1'b0, 1'b1, 32'h44, 32'h0, 1'b0);
    check("next_cycle_rd", obs_rd, 32'd5);
    drain_all();

    // Reset discards pending stores
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 32'h70 + 32'(4 * i), 32'hA0 + 32'(i), 1'b0);
    step(1'b0, 1'b1, 32'h0, 32'h0, 1'b1);
    step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    check("rst_discard_empty", {31'h0, obs_empty}, 32'h1);
    check("rst_discard_we", {31'h0, obs_mem_we}, 32'h0);
    check("rst_ram_70", tram[28], 32'h0);
    check("rst_ram_78", tram[30], 32'h0);

    // Random traffic over a narrow address window to provoke hits
    for (int n = 0; n < 600; n++) begin
      step(1'($urandom_range(0, 99) < 55), 1'($urandom_range(0, 99) < 40),
           32'h40 + 32'($urandom_range(0, 15) * 4) + 32'($urandom_range(0, 3)),
           $urandom, 1'($urandom_range(0, 99) < 2));
    end
    drain_all();
    for (int i = 0; i < 64; i++) check("ram_final", tram[i], mram[i]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
